icache_dm: RTL and testbench

Parametrised direct-mapped instruction cache that replaces the fixed, preloaded instruction store between the core fetch stage and the backing instruction memory. Hits return one word per cycle with 1-cycle latency. Misses stall the fetch port and refill a full line through a word-serial valid/ready memory port. A flush input invalidates all lines so the cache can be reused after code is loaded.

---
 rtl/icache_pkg.sv | 28 ++
 rtl/icache_if.sv | 28 ++
 rtl/icache_data_ram.sv | 34 +++
 rtl/icache_dm.sv | 213 +++++++++++++++++++++
 tb/tb_icache_dm.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REFILL_REQ  = 2'd1,
        REFILL_WAIT = 2'd2,
        RESP        = 2'd3
    } state_t;

    // Word-offset width inside a line.
    function automatic int unsigned off_width(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Line-index width.
    function automatic int unsigned idx_width(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Tag width: what remains above byte offset, word offset and index.
    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned lines,
                                              input int unsigned words_per_line);
        return addr_w - 2 - off_width(words_per_line) - idx_width(lines);
    endfunction

endpackage

// File: rtl/icache_if.sv
// Word-read bus: request handshake plus an unthrottled response pulse.
// Used for both the fetch side (cache is slave) and the memory side (cache is master).
interface icache_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/icache_data_ram.sv
// Cache data store: LINES*WORDS_PER_LINE words, one write port, one registered read port.
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned DATA_W         = 32,
    localparam int unsigned AW = idx_width(LINES) + off_width(WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [LINES*WORDS_PER_LINE];
    logic [DATA_W-1:0] r_rd_data;

    // Storage write and registered read; contents are not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with word-serial line refill.
// Define ICACHE_PERF_EN to add the perf_hits/perf_misses counters and ports.
module icache_dm
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    icache_if.slave  fetch,
    icache_if.master mem
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
`endif
);

    localparam int unsigned OFF_W = off_width(WORDS_PER_LINE);
    localparam int unsigned IDX_W = idx_width(LINES);
    localparam int unsigned TAG_W = tag_width(ADDR_W, LINES, WORDS_PER_LINE);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [TAG_W-1:0]   r_req_tag;
    logic [IDX_W-1:0]   r_req_idx;
    logic [OFF_W-1:0]   r_req_off;
    logic [OFF_W-1:0]   r_cnt;
    logic               r_flush_pend;

    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tags [LINES];

    logic               r_rsp_hit;
    logic [DATA_W-1:0]  r_fill_word;

    logic [TAG_W-1:0]   w_req_tag;
    logic [IDX_W-1:0]   w_req_idx;
    logic [OFF_W-1:0]   w_req_off;
    logic               w_accept;
    logic               w_hit;
    logic               w_miss;
    logic               w_fill;
    logic               w_last;
    logic [DATA_W-1:0]  w_ram_rdata;
    logic               w_unused_byte_bits;

    assign w_req_tag = fetch.req_addr[ADDR_W-1 -: TAG_W];
    assign w_req_idx = fetch.req_addr[2+OFF_W +: IDX_W];
    assign w_req_off = fetch.req_addr[2 +: OFF_W];
    assign w_unused_byte_bits = ^fetch.req_addr[1:0];

    // A flush coinciding with an accept forces a miss.
    assign w_accept = (r_state == IDLE) && fetch.req_valid;
    assign w_hit    = w_accept && !flush && r_valid[w_req_idx]
                      && (r_tags[w_req_idx] == w_req_tag);
    assign w_miss   = w_accept && !w_hit;
    assign w_fill   = (r_state == REFILL_WAIT) && mem.rsp_valid;
    assign w_last   = w_fill && (r_cnt == '1);

    icache_data_ram #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .DATA_W         (DATA_W)
    ) u_data_ram (
        .clk       (clk),
        .i_wr_en   (w_fill),
        .i_wr_addr ({r_req_idx, r_cnt}),
        .i_wr_data (mem.rsp_data),
        .i_rd_en   (w_accept),
        .i_rd_addr ({w_req_idx, w_req_off}),
        .o_rd_data (w_ram_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake/response outputs.
    always_comb begin
        w_state_nxt    = r_state;
        fetch.req_ready = 1'b0;
        fetch.rsp_valid = 1'b0;
        fetch.rsp_data  = '0;
        mem.req_valid   = 1'b0;
        mem.req_addr    = '0;

        // Hit data comes from the RAM read issued at accept; the refill
        // response uses the word captured while the line streamed in.
        if (r_rsp_hit) begin
            fetch.rsp_valid = 1'b1;
            fetch.rsp_data  = w_ram_rdata;
        end

        case (r_state)
            IDLE: begin
                fetch.req_ready = 1'b1;
                if (w_miss) begin
                    w_state_nxt = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                mem.req_valid = 1'b1;
                mem.req_addr  = {r_req_tag, r_req_idx, r_cnt, 2'b00};
                if (mem.req_ready) begin
                    w_state_nxt = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                if (mem.rsp_valid) begin
                    w_state_nxt = w_last ? RESP : REFILL_REQ;
                end
            end
            RESP: begin
                fetch.rsp_valid = 1'b1;
                fetch.rsp_data  = r_fill_word;
                w_state_nxt     = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Miss capture, refill word counter and flush-during-refill tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_tag    <= '0;
            r_req_idx    <= '0;
            r_req_off    <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
        end else if (w_miss) begin
            r_req_tag    <= w_req_tag;
            r_req_idx    <= w_req_idx;
            r_req_off    <= w_req_off;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_fill && !w_last) begin
                r_cnt <= r_cnt + OFF_W'(1);
            end
            if (flush && ((r_state == REFILL_REQ) || (r_state == REFILL_WAIT))) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    // Response registers: hit flag and the requested word seen during refill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_hit   <= 1'b0;
            r_fill_word <= '0;
        end else begin
            r_rsp_hit <= w_hit;
            if (w_fill && (r_cnt == r_req_off)) begin
                r_fill_word <= mem.rsp_data;
            end
        end
    end

    // Valid bits: flush wins over a completing refill; a line flushed mid-refill stays invalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_last && !r_flush_pend) begin
            r_valid[r_req_idx] <= 1'b1;
        end
    end

    // Tag array, written when the last word of a line arrives.
    always_ff @(posedge clk) begin
        if (w_last) begin
            r_tags[r_req_idx] <= r_req_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] r_perf_hits;
    logic [31:0] r_perf_misses;

    // Wrapping hit/miss counters, counted at accept and untouched by flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_hits   <= '0;
            r_perf_misses <= '0;
        end else begin
            if (w_hit) begin
                r_perf_hits <= r_perf_hits + 32'd1;
            end
            if (w_miss) begin
                r_perf_misses <= r_perf_misses + 32'd1;
            end
        end
    end

    assign perf_hits   = r_perf_hits;
    assign perf_misses = r_perf_misses;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm with a behavioural backing memory.
module tb_icache_dm;

    logic clk;
    logic rst_n;
    logic flush;

    icache_if #(.ADDR_W(32), .DATA_W(32)) fetch_if ();
    icache_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
`endif

    icache_dm #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .LINES          (16),
        .WORDS_PER_LINE (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .fetch (fetch_if),
        .mem   (mem_if)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;

    // Backing memory: word at byte address a holds a*32 + 0x13.
    int unsigned ready_delay = 0;
    int unsigned rsp_delay   = 0;
    bit          m_pend      = 1'b0;
    int unsigned m_cnt       = 0;
    int unsigned m_vcyc      = 0;
    logic [31:0] m_addr      = '0;

    initial begin
        mem_if.req_ready = 1'b0;
        mem_if.rsp_valid = 1'b0;
        mem_if.rsp_data  = '0;
        forever begin
            @(negedge clk);
            mem_if.rsp_valid = 1'b0;
            mem_if.req_ready = 1'b0;
            if (m_pend) begin
                if (m_cnt == 0) begin
                    mem_if.rsp_valid = 1'b1;
                    mem_if.rsp_data  = (m_addr << 5) + 32'h13;
                    m_pend = 1'b0;
                end else begin
                    m_cnt--;
                end
            end else if (mem_if.req_valid) begin
                if (m_vcyc >= ready_delay) begin
                    mem_if.req_ready = 1'b1;
                    m_pend = 1'b1;
                    m_cnt  = rsp_delay;
                    m_addr = mem_if.req_addr;
                    m_vcyc = 0;
                end else begin
                    m_vcyc++;
                end
            end
        end
    end

    // Bus monitors: handshake addresses, request stability, stray responses.
    logic [31:0] hs_q [$];
    int          stab_err  = 0;
    int          n_stray   = 0;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(posedge clk) begin
        if (rst_n && mem_if.req_valid && mem_if.req_ready) begin
            hs_q.push_back(mem_if.req_addr);
        end
        if (rst_n && prev_wait && (!mem_if.req_valid || (mem_if.req_addr !== prev_addr))) begin
            stab_err++;
        end
        prev_wait = rst_n && mem_if.req_valid && !mem_if.req_ready;
        prev_addr = mem_if.req_addr;
        if (rst_n && mem_if.rsp_valid && fetch_if.req_ready) begin
            n_stray++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One fetch; flush_at: -1 none, 0 together with the request, k>0 during cycle k after accept.
    task automatic do_fetch(input string name, input logic [31:0] addr, input logic [31:0] exp_data,
                            input int exp_lat, input int exp_hs, input int flush_at);
        int          lat;
        int          rdy_hi;
        logic [31:0] base;
        base = addr & 32'hFFFF_FFF0;
        @(negedge clk);
        hs_q.delete();
        chk({name, " req_ready"}, 32'(fetch_if.req_ready), 32'd1);
        fetch_if.req_valid = 1'b1;
        fetch_if.req_addr  = addr;
        flush = (flush_at == 0);
        @(posedge clk);
        #1;
        fetch_if.req_valid = 1'b0;
        flush  = 1'b0;
        lat    = 1;
        rdy_hi = 0;
        while (!fetch_if.rsp_valid && lat < 200) begin
            if (fetch_if.req_ready) rdy_hi++;
            flush = (flush_at == lat);
            @(posedge clk);
            #1;
            flush = 1'b0;
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " rsp_instr"}, fetch_if.rsp_data, exp_data);
        chk({name, " req_ready low"}, 32'(rdy_hi), 32'd0);
        if (exp_hs > 0) begin
            chk({name, " req_ready in RESP"}, 32'(fetch_if.req_ready), 32'd0);
        end
        chk({name, " mem reads"}, 32'(hs_q.size()), 32'(exp_hs));
        for (int i = 0; i < exp_hs && i < hs_q.size(); i++) begin
            chk({name, " mem addr"}, hs_q[i], base + 32'(4 * i));
        end
        @(posedge clk);
        #1;
        chk({name, " rsp pulse"}, 32'(fetch_if.rsp_valid), 32'd0);
    endtask

    logic [31:0] b_addr [3] = '{32'h0, 32'h4, 32'hC};
    logic [31:0] b_exp  [3] = '{32'h13, 32'h93, 32'h193};

    initial begin
        int act;
        rst_n = 1'b0;
        flush = 1'b0;
        fetch_if.req_valid = 1'b0;
        fetch_if.req_addr  = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst req_ready", 32'(fetch_if.req_ready), 32'd1);
        chk("rst rsp_valid", 32'(fetch_if.rsp_valid), 32'd0);
        chk("rst rsp_instr", fetch_if.rsp_data, 32'd0);
        chk("rst mem_req_valid", 32'(mem_if.req_valid), 32'd0);
        chk("rst mem_req_addr", mem_if.req_addr, 32'd0);
`ifdef ICACHE_PERF_EN
        chk("rst perf_hits", perf_hits, 32'd0);
        chk("rst perf_misses", perf_misses, 32'd0);
`endif
        rst_n = 1'b1;

        // Cold miss, then a hit in the filled line.
        do_fetch("cold 0x00", 32'h00, 32'h13, 9, 4, -1);
`ifdef ICACHE_PERF_EN
        chk("perf_misses after cold", perf_misses, 32'd1);
`endif
        do_fetch("hit 0x08", 32'h08, 32'h113, 1, 0, -1);

        // Back-to-back hits at one per cycle.
        hs_q.delete();
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("b2b rsp_valid", 32'(fetch_if.rsp_valid), 32'd1);
                chk("b2b rsp_instr", fetch_if.rsp_data, b_exp[i-1]);
            end
            if (i < 3) begin
                fetch_if.req_valid = 1'b1;
                fetch_if.req_addr  = b_addr[i];
            end else begin
                fetch_if.req_valid = 1'b0;
            end
        end
        chk("b2b mem reads", 32'(hs_q.size()), 32'd0);

        // Conflict eviction on index 0.
        do_fetch("conflict 0x100", 32'h100, 32'h2013, 9, 4, -1);
        do_fetch("conflict 0x00", 32'h00, 32'h13, 9, 4, -1);
        do_fetch("conflict 0x104", 32'h104, 32'h2093, 9, 4, -1);

        // Flush while idle invalidates a resident line.
        do_fetch("fill 0x10", 32'h10, 32'h213, 9, 4, -1);
        do_fetch("hit 0x14", 32'h14, 32'h293, 1, 0, -1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        do_fetch("after flush 0x14", 32'h14, 32'h293, 9, 4, -1);

        // Flush together with a request: treated as a miss, line valid afterwards.
        do_fetch("flush+req 0x18", 32'h18, 32'h313, 9, 4, 0);
        do_fetch("hit 0x18", 32'h18, 32'h313, 1, 0, -1);

        // Flush during refill: response delivered, line left invalid.
        do_fetch("flush mid 0x20", 32'h20, 32'h413, 9, 4, 3);
        do_fetch("refetch 0x20", 32'h20, 32'h413, 9, 4, -1);
        do_fetch("hit 0x24", 32'h24, 32'h493, 1, 0, -1);

        // Slow memory: ready held low 5 cycles, response 3 cycles after accept.
        ready_delay = 5;
        rsp_delay   = 3;
        do_fetch("stall 0x30", 32'h30, 32'h613, 41, 4, -1);
        chk("stall addr stable", 32'(stab_err), 32'd0);
        ready_delay = 0;
`ifdef ICACHE_PERF_EN
        chk("perf_hits total", perf_hits, 32'd7);
        chk("perf_misses total", perf_misses, 32'd10);
`endif

        // Reset in the middle of a refill; the in-flight response arrives in IDLE.
        @(negedge clk);
        fetch_if.req_valid = 1'b1;
        fetch_if.req_addr  = 32'h40;
        @(posedge clk);
        #1;
        fetch_if.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst req_ready", 32'(fetch_if.req_ready), 32'd1);
        chk("midrst rsp_valid", 32'(fetch_if.rsp_valid), 32'd0);
        chk("midrst rsp_instr", fetch_if.rsp_data, 32'd0);
        chk("midrst mem_req_valid", 32'(mem_if.req_valid), 32'd0);
        chk("midrst mem_req_addr", mem_if.req_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        repeat (4) begin
            @(negedge clk);
            if (fetch_if.rsp_valid || mem_if.req_valid) act++;
        end
        chk("stray rsp seen", 32'(n_stray), 32'd1);
        chk("stray rsp ignored", 32'(act), 32'd0);
`ifdef ICACHE_PERF_EN
        chk("midrst perf_misses", perf_misses, 32'd0);
`endif
        rsp_delay = 0;
        do_fetch("post-reset 0x00", 32'h00, 32'h13, 9, 4, -1);
`ifdef ICACHE_PERF_EN
        chk("post-reset perf_misses", perf_misses, 32'd1);
        chk("post-reset perf_hits", perf_hits, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
